// File: rtl/sys_pio_pkg.sv
// Shared register map and IRQ mode encodings for the edge-capturing PIO input block.
package sys_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_RSVD      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN   = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MODE  = 3'd6;
  localparam logic [2:0] ADDR_DB_LIMIT  = 3'd7;

  typedef enum logic {
    IRQ_MODE_LEVEL = 1'b0,
    IRQ_MODE_EDGE  = 1'b1
  } irq_mode_e;

  // Per-bit interrupt source: latched edge or live filtered level.
  function automatic logic irq_src(input irq_mode_e mode, input logic cap, input logic lvl);
    return (mode == IRQ_MODE_EDGE) ? cap : lvl;
  endfunction

endpackage

// File: rtl/sys_pio_debounce_bit.sv
// One-bit debounce filter: output toggles once the synchronized input has
// disagreed with it for db_limit+1 consecutive cycles; any agreement restarts the count.
module sys_pio_debounce_bit #(
  parameter int DB_CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sync,
  input  logic [DB_CNT_W-1:0] db_limit,
  output logic                filt
);

  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (cnt == db_limit) begin
      filt <= ~filt;
      cnt  <= '0;
    end else begin
      cnt <= cnt + DB_CNT_W'(1);
    end
  end

endmodule

// File: rtl/sys_pio_edge_in.sv
// Avalon-MM PIO input with synchronizer, edge capture (W1C) and level/edge IRQ; readdata has 1-cycle latency.
// Optional per-bit debounce filter enabled by macro SYS_PIO_DEBOUNCE_EN (default build: filt = sync).
module sys_pio_edge_in
  import sys_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mode;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] irq_vec;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef SYS_PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_limit <= '0;
    end else if (wr && address == ADDR_DB_LIMIT) begin
      db_limit <= writedata[DB_CNT_W-1:0];
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    sys_pio_debounce_bit #(.DB_CNT_W(DB_CNT_W)) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .sync     (sync[gi]),
      .db_limit (db_limit),
      .filt     (filt[gi])
    );
  end
`else
  assign filt = sync;
`endif

  // A set event in the same cycle as a W1C clear wins.
  assign cap_set = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
  assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_d   <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mode <= '0;
      readdata <= '0;
    end else begin
      filt_d   <= filt;
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      readdata <= rd_mux;
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_RISE_EN)  rise_en  <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_FALL_EN)  fall_en  <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_IRQ_MODE) irq_mode <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = filt;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
      ADDR_RISE_EN:  rd_mux[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN:  rd_mux[WIDTH-1:0] = fall_en;
      ADDR_IRQ_MODE: rd_mux[WIDTH-1:0] = irq_mode;
`ifdef SYS_PIO_DEBOUNCE_EN
      ADDR_DB_LIMIT: rd_mux[DB_CNT_W-1:0] = db_limit;
`endif
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    irq_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      irq_vec[i] = irq_mask[i] & irq_src(irq_mode_e'(irq_mode[i]), edge_cap[i], filt[i]);
    end
    irq = |irq_vec;
  end

endmodule

// File: doc/sys_pio_edge_in.md
SYS_PIO_EDGE_IN -- requirements
Module: sys_pio_edge_in

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of input pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-003 SHALL have parameter DB_CNT_W, default 16, debounce counter width (1..32).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 in_port  input  WIDTH  asynchronous external pins.
REQ-012 irq  output  1  interrupt request, active-high.

Function
REQ-013 SHALL pass in_port through a SYNC_STAGES flop chain; last stage = sync.
REQ-014 SHALL map registers: 0 DATA (RO, filtered), 2 IRQ_MASK, 3 EDGE_CAPTURE (W1C), 4 RISE_EN, 5 FALL_EN, 6 IRQ_MODE (1 = edge, 0 = level), 7 DB_LIMIT; addresses 1 and unused bits read 0, writes ignored.
REQ-015 Write = chipselect & ~write_n; registers 2, 4, 5, 6 and 7 load writedata[WIDTH-1:0] (DB_LIMIT: [DB_CNT_W-1:0]) on that clock edge.
REQ-016 readdata SHALL be registered every cycle from the address-selected mux, one-cycle latency, independent of chipselect.
REQ-017 Edge terms: rise = filt & ~filt_d, fall = ~filt & filt_d, where filt_d is filt delayed one cycle.
REQ-018 EDGE_CAPTURE bit i SHALL set on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
REQ-019 Writing 1 to EDGE_CAPTURE bit i SHALL clear it; a simultaneous set event wins, leaving the bit at 1.
REQ-020 irq SHALL be |(IRQ_MASK & ((IRQ_MODE & EDGE_CAPTURE) | (~IRQ_MODE & filt))), combinational from registers.
REQ-021 Capture SHALL proceed regardless of IRQ_MASK.

Reset
REQ-022 Reset SHALL clear sync chain, filt, filt_d, counters, all registers, readdata and irq to 0, asynchronously.
REQ-023 Reset mid-debounce SHALL discard partial counts; no edge SHALL be captured from the post-reset filt_d = 0 state unless sync is 1 after release.

Configuration
REQ-024 Macro SYS_PIO_DEBOUNCE_EN defined: per-bit counter increments while sync[i] != filt[i] and clears when they are equal; filt[i] toggles and the counter clears when count == DB_LIMIT, so the mismatch must persist DB_LIMIT+1 cycles.
REQ-025 SYS_PIO_DEBOUNCE_EN undefined: filt = sync; no counters; DB_LIMIT reads 0 and ignores writes.

Structure
REQ-026 Shared package sys_pio_pkg SHALL hold register address constants and IRQ_MODE encodings.
REQ-027 Per-bit debounce SHALL be sub-module sys_pio_debounce_bit, generate-instantiated WIDTH times, present only under SYS_PIO_DEBOUNCE_EN.

Verification
REQ-028 No debounce, SYNC_STAGES=2, RISE_EN=1, in_port[0] 0->1 before edge 1 -> EDGE_CAPTURE[0]=1 after edge 3; reading address 3 returns 0x1.
REQ-029 IRQ_MASK=0x1, IRQ_MODE=0x1, capture set -> irq=1; write 0x1 to address 3 -> irq=0 on the next cycle.
REQ-030 Debounce, DB_LIMIT=3, in_port[2] pulses high for 3 cycles -> DATA stays 0 and no capture; held high for 4 cycles -> DATA[2]=1.
REQ-031 FALL_EN=0x2, RISE_EN=0, in_port[1] 1->0 -> capture bit 1; a 0->1 transition -> no capture.
REQ-032 W1C of bit 0 in the same cycle as a new rise on bit 0 -> bit stays 1.
REQ-033 IRQ_MODE=0, IRQ_MASK=0x8, in_port[3] held high -> irq=1; irq=0 once filt[3] falls; reset_n asserted mid-operation -> readdata=0 and irq=0 immediately.
